fpcmult_initiator: RTL and testbench

FPCMULT_INITIATOR -- requirements
Module: fpcmult_initiator

---
 rtl/fpcmult_pkg.sv | 17 +
 rtl/fpcmult_resp_fifo.sv | 54 +++++
 rtl/fpcmult_initiator.sv | 134 +++++++++++++
 tb/tb_fpcmult_initiator.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpcmult_pkg.sv
// Shared types and constants for the complex fixed-point multiplier initiator.
// Provides the control-FSM state enum, the latency counter width and a saturating increment.
package fpcmult_pkg;

  localparam int unsigned LAT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  function automatic logic [LAT_W-1:0] lat_sat_inc(input logic [LAT_W-1:0] lat);
    return (lat == '1) ? lat : lat + 1'b1;
  endfunction

endpackage

// File: rtl/fpcmult_resp_fifo.sv
// Result buffer: circular FIFO, power-of-two depth, registered storage.
// The head is read combinationally from storage.
module fpcmult_resp_fifo #(
  parameter int unsigned Width = 72,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic [Width-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [Width-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             pop_ok;

  // The initiator reserves a slot before issuing, so push never sees a full buffer.
  assign pop_ok = pop && (count_q != '0);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fpcmult_initiator.sv
// Drives one request at a time into a complex multiplier, timestamps each response's
// latency and queues {cr, cc, lat} results in order for a downstream consumer.
module fpcmult_initiator
  import fpcmult_pkg::*;
#(
  parameter int unsigned n     = 32,
  parameter int unsigned d     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  // Upstream operands
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [n-1:0]     in_ar,
  input  logic [n-1:0]     in_ac,
  input  logic [n-1:0]     in_br,
  input  logic [n-1:0]     in_bc,
  // Request to multiplier
  output logic             m_recv_val,
  input  logic             m_recv_rdy,
  output logic [n-1:0]     m_ar,
  output logic [n-1:0]     m_ac,
  output logic [n-1:0]     m_br,
  output logic [n-1:0]     m_bc,
  // Response from multiplier
  input  logic             m_send_val,
  output logic             m_send_rdy,
  input  logic [n-1:0]     m_cr,
  input  logic [n-1:0]     m_cc,
  // Downstream results
  output logic             out_val,
  input  logic             out_rdy,
  output logic [n-1:0]     out_cr,
  output logic [n-1:0]     out_cc,
  output logic [LAT_W-1:0] out_lat,
  output logic [15:0]      ops_done
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned EntW = 2 * n + LAT_W;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  // d only describes the operand format for the multiplier; reject nonsensical setups.
  if (d > n || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("fpcmult_initiator: need d <= n and DEPTH a power of two >= 2");
  end

  state_e           state_q, state_d;
  logic [n-1:0]     ar_q, ac_q, br_q, bc_q;
  logic [LAT_W-1:0] lat_q, lat_d, lat_inc;
  logic [15:0]      ops_done_q;
  logic             in_hs, issue_hs, cap_hs;
  logic [CntW-1:0]  fifo_count;
  logic [EntW-1:0]  fifo_head;

  // Outstanding is always zero in IDLE, so the reservation reduces to count < DEPTH.
  assign in_rdy     = reset && (state_q == IDLE) && (fifo_count < DepthCnt);
  assign m_recv_val = (state_q == ISSUE);
  assign m_send_rdy = (state_q == WAIT);

  assign in_hs    = in_val && in_rdy;
  assign issue_hs = m_recv_val && m_recv_rdy;
  assign cap_hs   = m_send_val && m_send_rdy;
  assign lat_inc  = lat_sat_inc(lat_q);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE: begin
        if (in_hs) state_d = ISSUE;
      end
      ISSUE: begin
        if (issue_hs) begin
          state_d = WAIT;
          lat_d   = '0;
        end
      end
      WAIT: begin
        lat_d = lat_inc;
        if (cap_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ar_q       <= '0;
      ac_q       <= '0;
      br_q       <= '0;
      bc_q       <= '0;
      lat_q      <= '0;
      ops_done_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (in_hs) begin
        ar_q <= in_ar;
        ac_q <= in_ac;
        br_q <= in_br;
        bc_q <= in_bc;
      end
      if (cap_hs) ops_done_q <= ops_done_q + 16'd1;
    end
  end

  assign m_ar     = ar_q;
  assign m_ac     = ac_q;
  assign m_br     = br_q;
  assign m_bc     = bc_q;
  assign ops_done = ops_done_q;

  fpcmult_resp_fifo #(
    .Width (EntW),
    .DEPTH (DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cap_hs),
    .push_data ({m_cr, m_cc, lat_inc}),
    .pop       (out_val && out_rdy),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign out_val = reset && (fifo_count != '0);
  assign out_cr  = fifo_head[EntW-1 -: n];
  assign out_cc  = fifo_head[LAT_W +: n];
  assign out_lat = fifo_head[LAT_W-1:0];

endmodule

// File: tb/tb_fpcmult_initiator.sv
// Directed bench for fpcmult_initiator with a Q16.16 complex-multiplier stub
// whose reply delay is chosen per request.
module tb_fpcmult_initiator;

  typedef struct {
    logic [31:0] ar, ac, br, bc;
    logic [31:0] cr, cc;
    int          delay;
    logic [7:0]  lat;
  } vec_t;

  localparam int NV = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_val = 1'b0, in_rdy;
  logic [31:0] in_ar = '0, in_ac = '0, in_br = '0, in_bc = '0;
  logic        m_recv_val, m_recv_rdy = 1'b1;
  logic [31:0] m_ar, m_ac, m_br, m_bc;
  logic        m_send_val, m_send_rdy;
  logic [31:0] m_cr, m_cc;
  logic        out_val, out_rdy = 1'b0;
  logic [31:0] out_cr, out_cc;
  logic [7:0]  out_lat;
  logic [15:0] ops_done;

  int errors = 0;
  int checks = 0;
  vec_t vecs[NV];

  // Multiplier stub state
  logic        stub_pending = 1'b0;
  int          stub_cnt = 0;
  int          stub_cur_delay = 1;
  int          stub_delay = 1;
  logic        hold_sv = 1'b0;
  logic [31:0] stub_cr = '0, stub_cc = '0;

  always #5 clk = ~clk;

  fpcmult_initiator dut (
    .clk        (clk),
    .reset      (reset),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_ar      (in_ar),
    .in_ac      (in_ac),
    .in_br      (in_br),
    .in_bc      (in_bc),
    .m_recv_val (m_recv_val),
    .m_recv_rdy (m_recv_rdy),
    .m_ar       (m_ar),
    .m_ac       (m_ac),
    .m_br       (m_br),
    .m_bc       (m_bc),
    .m_send_val (m_send_val),
    .m_send_rdy (m_send_rdy),
    .m_cr       (m_cr),
    .m_cc       (m_cc),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_cr     (out_cr),
    .out_cc     (out_cc),
    .out_lat    (out_lat),
    .ops_done   (ops_done)
  );

  function automatic logic [31:0] q_re(input logic [31:0] ar, ac, br, bc);
    longint p;
    p = longint'($signed(ar)) * longint'($signed(br)) - longint'($signed(ac)) * longint'($signed(bc));
    return p[47:16];
  endfunction

  function automatic logic [31:0] q_im(input logic [31:0] ar, ac, br, bc);
    longint p;
    p = longint'($signed(ar)) * longint'($signed(bc)) + longint'($signed(ac)) * longint'($signed(br));
    return p[47:16];
  endfunction

  // Stub: replies stub_cur_delay cycles into WAIT; hold_sv models send_val held between ops.
  always @(posedge clk) begin
    if (m_recv_val && m_recv_rdy) begin
      stub_cr        <= q_re(m_ar, m_ac, m_br, m_bc);
      stub_cc        <= q_im(m_ar, m_ac, m_br, m_bc);
      stub_cur_delay <= stub_delay;
      stub_pending   <= 1'b1;
      stub_cnt       <= 1;
    end else if (m_send_val && m_send_rdy) begin
      stub_pending <= 1'b0;
    end else if (stub_pending) begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  assign m_send_val = (stub_pending && stub_cnt >= stub_cur_delay) || hold_sv;
  assign m_cr = stub_cr;
  assign m_cc = stub_cc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // in_rdy must never be high while a request is in ISSUE or WAIT.
  always @(negedge clk) begin
    if (reset && (m_recv_val || m_send_rdy)) chk("in_rdy_busy", in_rdy, 1'b0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    in_val  = 1'b0;
    out_rdy = 1'b0;
    m_recv_rdy = 1'b1;
    hold_sv = 1'b0;
    step();
    step();
    chk("rst_ctrl", {in_rdy, out_val, m_recv_val, m_send_rdy}, 4'b0000);
    chk("rst_ops", ops_done, 16'd0);
    chk("rst_mops", {m_ar, m_ac, m_br, m_bc}, 128'd0);
    reset = 1'b1;
    step();
    chk("rst_in_rdy", in_rdy, 1'b1);
  endtask

  task automatic send_op(input vec_t v);
    int guard;
    guard = 0;
    in_ar = v.ar;
    in_ac = v.ac;
    in_br = v.br;
    in_bc = v.bc;
    in_val = 1'b1;
    while (!in_rdy && guard < 2000) begin
      step();
      guard++;
    end
    chk("send_accept", in_rdy, 1'b1);
    stub_delay = v.delay;
    step();
    in_val = 1'b0;
  endtask

  task automatic wait_out(input int limit);
    int guard;
    guard = 0;
    while (!out_val && guard < limit) begin
      step();
      guard++;
    end
  endtask

  task automatic wait_ops(input logic [15:0] target);
    int guard;
    guard = 0;
    while (ops_done != target && guard < 500) begin
      step();
      guard++;
    end
    chk("ops_reach", ops_done, target);
  endtask

  task automatic expect_head(input string name, input vec_t v);
    chk(name, {out_val, out_cr, out_cc, out_lat}, {1'b1, v.cr, v.cc, v.lat});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    // ar, ac, br, bc, expected cr, expected cc, stub delay, expected lat
    vecs[0] = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000,
                32'hFFFB_0000, 32'h000A_0000, 3, 8'd3};
    vecs[1] = '{32'h0000_8000, 32'h0000_0000, 32'h0002_0000, 32'hFFFF_0000,
                32'h0001_0000, 32'hFFFF_8000, 1, 8'd1};
    vecs[2] = '{32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                32'h0002_0000, 32'h0000_0000, 2, 8'd2};
    vecs[3] = '{32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 32'h0001_0000,
                32'hFFFF_0000, 32'h0000_0000, 5, 8'd5};
    vecs[4] = '{32'h0001_8000, 32'h0000_4000, 32'h0002_0000, 32'h0000_0000,
                32'h0003_0000, 32'h0000_8000, 1, 8'd1};

    // Single op, result appears the cycle after capture
    do_reset();
    send_op(vecs[0]);
    begin
      int guard;
      guard = 0;
      while (!(m_send_val && m_send_rdy) && guard < 100) begin
        step();
        guard++;
      end
    end
    chk("cap_seen", {m_send_val, m_send_rdy}, 2'b11);
    chk("pre_cap_out_val", out_val, 1'b0);
    step();
    expect_head("single_res", vecs[0]);
    chk("single_ops", ops_done, 16'd1);

    // Back-to-back stream with consumer always ready
    do_reset();
    out_rdy = 1'b1;
    fork
      begin
        for (int i = 0; i < NV; i++) send_op(vecs[i]);
      end
      begin
        int got;
        int guard;
        got = 0;
        guard = 0;
        while (got < NV && guard < 500) begin
          if (out_val) begin
            expect_head($sformatf("b2b_res%0d", got), vecs[got]);
            got++;
          end
          step();
          guard++;
        end
        chk("b2b_count", got, NV);
      end
    join
    chk("b2b_ops", ops_done, 16'd5);
    chk("b2b_empty", out_val, 1'b0);

    // Backpressure: buffer of 4 fills, one pop admits exactly one more op
    do_reset();
    for (int i = 0; i < 4; i++) send_op(vecs[i]);
    wait_ops(16'd4);
    in_ar = vecs[4].ar;
    in_ac = vecs[4].ac;
    in_br = vecs[4].br;
    in_bc = vecs[4].bc;
    in_val = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("bp_blocked", in_rdy, 1'b0);
    chk("bp_ops4", ops_done, 16'd4);
    expect_head("bp_head0", vecs[0]);
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    chk("bp_reopen", in_rdy, 1'b1);
    stub_delay = vecs[4].delay;
    step();
    in_val = 1'b0;
    wait_ops(16'd5);
    step();
    chk("bp_full_again", in_rdy, 1'b0);
    out_rdy = 1'b1;
    for (int k = 1; k < NV; k++) begin
      expect_head($sformatf("bp_drain%0d", k), vecs[k]);
      step();
    end
    chk("bp_drained", out_val, 1'b0);

    // Request stall and latency saturation
    do_reset();
    m_recv_rdy = 1'b0;
    out_rdy = 1'b1;
    send_op(vecs[0]);
    stub_delay = 300;
    for (int i = 0; i < 10; i++) begin
      chk("stall_val", m_recv_val, 1'b1);
      chk("stall_ops", {m_ar, m_ac, m_br, m_bc}, {vecs[0].ar, vecs[0].ac, vecs[0].br, vecs[0].bc});
      step();
    end
    m_recv_rdy = 1'b1;
    wait_out(400);
    chk("stall_res", {out_val, out_cr, out_cc, out_lat}, {1'b1, vecs[0].cr, vecs[0].cc, 8'hFF});

    // Reset while waiting on the multiplier; the late reply must be ignored
    do_reset();
    send_op(vecs[1]);
    stub_delay = 1000;
    begin
      int guard;
      guard = 0;
      while (!m_send_rdy && guard < 50) begin
        step();
        guard++;
      end
    end
    chk("wr_in_wait", m_send_rdy, 1'b1);
    step();
    step();
    reset = 1'b0;
    hold_sv = 1'b1;
    #1;
    chk("wr_rst_low", {m_send_rdy, out_val, in_rdy}, 3'b000);
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("wr_no_push", {out_val, ops_done}, 17'd0);
    chk("wr_idle", {in_rdy, m_send_rdy}, 2'b10);
    hold_sv = 1'b0;

    // Simultaneous push and pop at count 2
    do_reset();
    send_op(vecs[1]);
    send_op(vecs[2]);
    wait_ops(16'd2);
    send_op(vecs[4]);
    begin
      int guard;
      guard = 0;
      while (!(m_send_val && m_send_rdy) && guard < 100) begin
        step();
        guard++;
      end
    end
    chk("pp_cap", {m_send_val, m_send_rdy}, 2'b11);
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    chk("pp_count", dut.fifo_count, 3'd2);
    expect_head("pp_head", vecs[2]);
    out_rdy = 1'b1;
    step();
    expect_head("pp_tail", vecs[4]);
    step();
    chk("pp_empty", out_val, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
